// File: rtl/pkt_slot_ctrl.sv
// Multi-slot packet buffer controller: fills slots from the input queue, offers
// filled slots to the processor, then streams finished slots to the output queue.

module pkt_slot_ent #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fill,
   input  logic              done,
   input  logic              free,
   input  logic [ADDR_W-1:0] start_d,
   input  logic [ADDR_W-1:0] end_d,
   output logic              is_filled,
   output logic              is_done,
   output logic              nxt_free,
   output logic [ADDR_W-1:0] start_addr,
   output logic [ADDR_W-1:0] end_addr
);
   typedef enum logic [1:0] {FREE, FILLED, DONE} slot_e;
   slot_e st, st_nxt;

   // fill/done/free only fire from FREE/FILLED/DONE respectively, so at most one hits a slot
   always_comb begin
      st_nxt = st;
      if (fill) st_nxt = FILLED;
      if (done) st_nxt = DONE;
      if (free) st_nxt = FREE;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st         <= FREE;
         start_addr <= '0;
         end_addr   <= '0;
      end else begin
         st <= st_nxt;
         if (fill) begin
            start_addr <= start_d;
            end_addr   <= end_d;
         end
      end
   end

   assign is_filled = (st == FILLED);
   assign is_done   = (st == DONE);
   assign nxt_free  = (st_nxt == FREE);
endmodule

module pkt_slot_ctrl #(
   parameter int DATA_W    = 64,
   parameter int CTRL_W    = 8,
   parameter int ADDR_W    = 8,
   parameter int NUM_SLOTS = 2,
   localparam int SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_wr,
   input  logic [CTRL_W-1:0]        in_ctrl,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_rdy,
   output logic                     mem_wen,
   output logic [ADDR_W-1:0]        mem_wr_addr,
   output logic [CTRL_W+DATA_W-1:0] mem_wr_data,
   output logic [ADDR_W-1:0]        mem_rd_addr,
   input  logic [CTRL_W+DATA_W-1:0] mem_rd_data,
   output logic                     pkt_rdy,
   output logic [SLOT_W-1:0]        pkt_slot,
   output logic [ADDR_W-1:0]        pkt_start_addr,
   output logic [ADDR_W-1:0]        pkt_end_addr,
   input  logic                     proc_done,
   output logic                     out_wr,
   output logic [CTRL_W-1:0]        out_ctrl,
   output logic [DATA_W-1:0]        out_data,
   input  logic                     out_rdy,
   output logic [15:0]              drop_cnt
);
   localparam int OFF_W = ADDR_W - SLOT_W;

   typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} wst_e;
   typedef enum logic {R_IDLE, R_STREAM} rst_e;

   wst_e w_st, w_nxt;
   rst_e r_st, r_nxt;
   logic [SLOT_W-1:0] wr_slot, wr_slot_nxt, proc_slot, rd_slot;
   logic [OFF_W:0]    wr_cnt, wr_cnt_nxt;
   logic [ADDR_W-1:0] wr_addr, base_addr;
   logic accept, ctrl_nz, wen_d, fill_ev, drop_ev, done_ev, free_ev, issue, rd_last;
   logic [NUM_SLOTS-1:0] fill_v, done_v, free_v, is_filled, is_done, nxt_free;
   logic [NUM_SLOTS-1:0][ADDR_W-1:0] slot_start, slot_end;

   assign accept    = in_wr & in_rdy;
   assign ctrl_nz   = |in_ctrl;
   assign base_addr = {wr_slot, {OFF_W{1'b0}}};
   assign wr_addr   = (w_st == W_IDLE) ? base_addr : {wr_slot, wr_cnt[OFF_W-1:0]};

   for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
      assign fill_v[s] = fill_ev & (wr_slot == SLOT_W'(s));
      assign done_v[s] = done_ev & (proc_slot == SLOT_W'(s));
      assign free_v[s] = free_ev & (rd_slot == SLOT_W'(s));
      pkt_slot_ent #(.ADDR_W(ADDR_W)) u_ent (
         .clk(clk), .reset(reset), .fill(fill_v[s]), .done(done_v[s]), .free(free_v[s]),
         .start_d(base_addr), .end_d(wr_addr), .is_filled(is_filled[s]), .is_done(is_done[s]),
         .nxt_free(nxt_free[s]), .start_addr(slot_start[s]), .end_addr(slot_end[s])
      );
   end

   // wr_cnt counts words already in the slot; its top bit set means the slot is full
   always_comb begin
      w_nxt      = w_st;
      wen_d      = 1'b0;
      fill_ev    = 1'b0;
      drop_ev    = 1'b0;
      wr_cnt_nxt = wr_cnt;
      if (accept) begin
         case (w_st)
            W_IDLE: if (ctrl_nz) begin
               wen_d      = 1'b1;
               wr_cnt_nxt = {{OFF_W{1'b0}}, 1'b1};
               w_nxt      = W_FILL;
            end
            W_FILL: if (wr_cnt[OFF_W]) begin
               drop_ev = 1'b1;
               w_nxt   = ctrl_nz ? W_IDLE : W_DROP;
            end else begin
               wen_d      = 1'b1;
               wr_cnt_nxt = wr_cnt + 1'b1;
               if (ctrl_nz) begin
                  fill_ev = 1'b1;
                  w_nxt   = W_IDLE;
               end
            end
            W_DROP: if (ctrl_nz) w_nxt = W_IDLE;
            default: w_nxt = W_IDLE;
         endcase
      end
   end

   assign wr_slot_nxt = fill_ev ? wr_slot + 1'b1 : wr_slot;

   assign pkt_rdy        = is_filled[proc_slot];
   assign pkt_slot       = proc_slot;
   assign pkt_start_addr = slot_start[proc_slot];
   assign pkt_end_addr   = slot_end[proc_slot];
   assign done_ev        = proc_done & pkt_rdy;

   // rd_last: end address already issued, waiting for its word to leave on out_*
   always_comb begin
      r_nxt   = r_st;
      issue   = 1'b0;
      free_ev = 1'b0;
      case (r_st)
         R_IDLE: if (is_done[rd_slot]) r_nxt = R_STREAM;
         R_STREAM: begin
            issue = out_rdy & ~rd_last;
            if (rd_last & out_wr) begin
               free_ev = 1'b1;
               r_nxt   = R_IDLE;
            end
         end
         default: r_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         w_st <= W_IDLE;
         r_st <= R_IDLE;
      end else begin
         w_st <= w_nxt;
         r_st <= r_nxt;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_slot     <= '0;
         proc_slot   <= '0;
         rd_slot     <= '0;
         wr_cnt      <= '0;
         in_rdy      <= 1'b0;
         mem_wen     <= 1'b0;
         mem_wr_addr <= '0;
         mem_wr_data <= '0;
         mem_rd_addr <= '0;
         rd_last     <= 1'b0;
         out_wr      <= 1'b0;
         drop_cnt    <= '0;
      end else begin
         wr_slot <= wr_slot_nxt;
         wr_cnt  <= wr_cnt_nxt;
         // next-state view so a slot freed this cycle is claimable next cycle
         in_rdy  <= (w_nxt != W_IDLE) | nxt_free[wr_slot_nxt];
         mem_wen <= wen_d;
         if (wen_d) begin
            mem_wr_addr <= wr_addr;
            mem_wr_data <= {in_ctrl, in_data};
         end
         if (done_ev) proc_slot <= proc_slot + 1'b1;
         if (free_ev) rd_slot <= rd_slot + 1'b1;
         out_wr <= issue;
         if (r_st == R_IDLE && r_nxt == R_STREAM)
            mem_rd_addr <= slot_start[rd_slot];
         else if (issue && mem_rd_addr != slot_end[rd_slot])
            mem_rd_addr <= mem_rd_addr + 1'b1;
         if (issue && mem_rd_addr == slot_end[rd_slot]) rd_last <= 1'b1;
         else if (free_ev) rd_last <= 1'b0;
         if (drop_ev && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
      end
   end

   assign out_ctrl = out_wr ? mem_rd_data[CTRL_W+DATA_W-1:DATA_W] : '0;
   assign out_data = out_wr ? mem_rd_data[DATA_W-1:0] : '0;
endmodule

// File: tb/tb_pkt_slot_ctrl.sv
// Directed bench for pkt_slot_ctrl: word table plus hand sequences for
// back-to-back stall, oversize drop, out_rdy toggling and mid-packet reset.

module tb_pkt_slot_ctrl;
   localparam int DATA_W = 64, CTRL_W = 8, ADDR_W = 8, NUM_SLOTS = 2;

   logic clk = 1'b0, rst_n = 1'b0;
   logic in_wr = 1'b0, proc_done = 1'b0, out_rdy = 1'b1;
   logic [7:0] in_ctrl = '0;
   logic [63:0] in_data = '0;
   logic in_rdy, mem_wen, pkt_rdy, out_wr;
   logic [7:0] mem_wr_addr, mem_rd_addr, pkt_start_addr, pkt_end_addr, out_ctrl;
   logic [71:0] mem_wr_data, mem_rd_data;
   logic [0:0] pkt_slot;
   logic [63:0] out_data;
   logic [15:0] drop_cnt;

   always #5 clk = ~clk;

   pkt_slot_ctrl #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .ADDR_W(ADDR_W), .NUM_SLOTS(NUM_SLOTS)) dut (
      .clk(clk), .reset(rst_n), .in_wr(in_wr), .in_ctrl(in_ctrl), .in_data(in_data),
      .in_rdy(in_rdy), .mem_wen(mem_wen), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .pkt_rdy(pkt_rdy), .pkt_slot(pkt_slot),
      .pkt_start_addr(pkt_start_addr), .pkt_end_addr(pkt_end_addr), .proc_done(proc_done),
      .out_wr(out_wr), .out_ctrl(out_ctrl), .out_data(out_data), .out_rdy(out_rdy), .drop_cnt(drop_cnt)
   );

   // synchronous packet memory, one-cycle read latency
   logic [71:0] mem [0:255];
   always @(posedge clk) begin
      if (mem_wen) mem[mem_wr_addr] <= mem_wr_data;
      mem_rd_data <= mem[mem_rd_addr];
   end

   logic [71:0] got_q[$], exp_q[$];
   always @(negedge clk) if (out_wr) got_q.push_back({out_ctrl, out_data});

   int n_vec = 0, n_err = 0;

   typedef struct {
      logic [7:0]  ctrl;
      logic [63:0] data;
      logic        wen;
      logic [7:0]  addr;
      logic        push;
   } vec_t;
   vec_t tbl[9];

   task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic send_word(input string nm, input logic [7:0] c, input logic [63:0] d,
                            input logic wen, input logic [7:0] a, input logic push);
      in_ctrl = c;
      in_data = d;
      in_wr   = 1'b1;
      for (int k = 0; k < 200 && !in_rdy; k++) @(negedge clk);
      chk({nm, "_rdy"}, in_rdy, 1);
      @(negedge clk);
      chk({nm, "_wen"}, mem_wen, wen);
      if (wen) begin
         chk({nm, "_addr"}, mem_wr_addr, a);
         chk({nm, "_wdata"}, mem_wr_data, {c, d});
      end
      if (push) exp_q.push_back({c, d});
      in_wr = 1'b0;
   endtask

   task automatic pulse_done();
      proc_done = 1'b1;
      @(negedge clk);
      proc_done = 1'b0;
   endtask

   task automatic drain(input string nm, input logic toggle);
      for (int k = 0; k < 400 && got_q.size() < exp_q.size(); k++) begin
         @(negedge clk);
         if (toggle) out_rdy = ~out_rdy;
      end
      out_rdy = 1'b1;
      repeat (4) @(negedge clk);
      chk({nm, "_count"}, got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         chk($sformatf("%s_word%0d", nm, i), got_q[i], exp_q[i]);
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_in_rdy"}, in_rdy, 0);
      chk({nm, "_mem_wen"}, mem_wen, 0);
      chk({nm, "_wr_addr"}, mem_wr_addr, 0);
      chk({nm, "_wr_data"}, mem_wr_data, 0);
      chk({nm, "_rd_addr"}, mem_rd_addr, 0);
      chk({nm, "_pkt"}, {pkt_rdy, pkt_slot, pkt_start_addr, pkt_end_addr}, 0);
      chk({nm, "_out"}, {out_wr, out_ctrl, out_data}, 0);
      chk({nm, "_drop"}, drop_cnt, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{8'h00, 64'h1111, 1'b0, 8'd0, 1'b0};
      tbl[1] = '{8'h00, 64'h2222, 1'b0, 8'd0, 1'b0};
      tbl[2] = '{8'hFF, 64'hA000_0000_0000_0001, 1'b1, 8'd0, 1'b1};
      tbl[3] = '{8'h00, 64'hA000_0000_0000_0002, 1'b1, 8'd1, 1'b1};
      tbl[4] = '{8'h00, 64'hA000_0000_0000_0003, 1'b1, 8'd2, 1'b1};
      tbl[5] = '{8'h04, 64'hA000_0000_0000_0004, 1'b1, 8'd3, 1'b1};
      tbl[6] = '{8'hFF, 64'hE000_0000_0000_0001, 1'b1, 8'd0, 1'b1};
      tbl[7] = '{8'h00, 64'hE000_0000_0000_0002, 1'b1, 8'd1, 1'b1};
      tbl[8] = '{8'h03, 64'hE000_0000_0000_0003, 1'b1, 8'd2, 1'b1};

      // reset state
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);
      chk("in_rdy_after_reset", in_rdy, 1);

      // proc_done with nothing offered is ignored
      pulse_done();
      chk("stray_done_pkt_rdy", pkt_rdy, 0);
      chk("stray_done_in_rdy", in_rdy, 1);

      // leading ctrl==0 words, then 4-word packet A
      for (int i = 0; i < 6; i++)
         send_word($sformatf("tblA%0d", i), tbl[i].ctrl, tbl[i].data, tbl[i].wen, tbl[i].addr, tbl[i].push);
      chk("A_pkt_rdy", pkt_rdy, 1);
      chk("A_pkt_slot", pkt_slot, 0);
      chk("A_pkt_start", pkt_start_addr, 0);
      chk("A_pkt_end", pkt_end_addr, 3);
      repeat (10) @(negedge clk);
      pulse_done();
      chk("A_pkt_rdy_fall", pkt_rdy, 0);
      drain("A_out", 1'b0);

      // back-to-back B (slot 1) and C (slot 0, proves slot 0 freed), no proc_done
      send_word("B0", 8'hFF, 64'hB1, 1'b1, 8'd128, 1'b1);
      send_word("B1", 8'h00, 64'hB2, 1'b1, 8'd129, 1'b1);
      send_word("B2", 8'h05, 64'hB3, 1'b1, 8'd130, 1'b1);
      send_word("C0", 8'hFF, 64'hC1, 1'b1, 8'd0, 1'b1);
      send_word("C1", 8'h02, 64'hC2, 1'b1, 8'd1, 1'b1);
      chk("full_in_rdy_low", in_rdy, 0);
      chk("B_pkt_slot", pkt_slot, 1);
      chk("B_pkt_start", pkt_start_addr, 128);
      chk("B_pkt_end", pkt_end_addr, 130);
      in_ctrl = 8'hFF;
      in_data = 64'hD1;
      in_wr   = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("stall%0d", i), {in_rdy, mem_wen}, 2'b00);
      end
      pulse_done();
      chk("C_pkt_rdy", pkt_rdy, 1);
      chk("C_pkt_slot", pkt_slot, 0);
      chk("C_pkt_end", pkt_end_addr, 1);
      send_word("D0", 8'hFF, 64'hD1, 1'b1, 8'd128, 1'b1);
      send_word("D1", 8'h01, 64'hD2, 1'b1, 8'd129, 1'b1);
      pulse_done();
      @(negedge clk);
      chk("D_pkt_slot", pkt_slot, 1);
      chk("D_pkt_start", pkt_start_addr, 128);
      chk("D_pkt_end", pkt_end_addr, 129);
      pulse_done();
      drain("BCD_out", 1'b0);

      // oversize 130-word packet into slot 0: 128 written, rest discarded
      for (int i = 0; i < 130; i++)
         send_word($sformatf("ovr%0d", i), (i == 0) ? 8'hFF : (i == 129) ? 8'h04 : 8'h00,
                   64'(i), (i < 128), 8'(i), 1'b0);
      chk("ovr_drop_cnt", drop_cnt, 1);
      chk("ovr_pkt_rdy", pkt_rdy, 0);
      for (int i = 6; i < 9; i++)
         send_word($sformatf("tblE%0d", i), tbl[i].ctrl, tbl[i].data, tbl[i].wen, tbl[i].addr, tbl[i].push);
      chk("E_pkt_rdy", pkt_rdy, 1);
      chk("E_pkt_slot", pkt_slot, 0);
      chk("E_pkt_end", pkt_end_addr, 2);
      pulse_done();
      drain("E_out", 1'b0);

      // 6-word packet F in slot 1 streamed with out_rdy toggling
      for (int i = 0; i < 6; i++)
         send_word($sformatf("F%0d", i), (i == 0) ? 8'hFF : (i == 5) ? 8'h06 : 8'h00,
                   64'hF0 + 64'(i), 1'b1, 8'(128 + i), 1'b1);
      chk("F_pkt_end", pkt_end_addr, 133);
      pulse_done();
      drain("F_toggle", 1'b1);

      // reset during word 3 of packet G
      send_word("G0", 8'hFF, 64'h61, 1'b1, 8'd0, 1'b0);
      send_word("G1", 8'h00, 64'h62, 1'b1, 8'd1, 1'b0);
      in_ctrl = 8'h00;
      in_data = 64'h63;
      in_wr   = 1'b1;
      rst_n   = 1'b0;
      #1;
      chk_all_zero("midrst");
      @(negedge clk);
      in_wr = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      got_q.delete();
      exp_q.delete();
      send_word("H0", 8'hFF, 64'h71, 1'b1, 8'd0, 1'b1);
      send_word("H1", 8'h07, 64'h72, 1'b1, 8'd1, 1'b1);
      chk("H_pkt_slot", pkt_slot, 0);
      chk("H_pkt_end", pkt_end_addr, 1);
      pulse_done();
      drain("H_out", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
